// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode/function-field constants and branch classes for the branch predict unit.
package branch_predict_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BGEZ    = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLTZ    = 6'h07;

  localparam logic [5:0] FUNC_JR    = 6'h08;
  localparam logic [5:0] FUNC_JALR  = 6'h09;
  localparam logic [5:0] FUNC_TEQ   = 6'h34;

  // Only BR_COND resolves train the history table.
  typedef enum logic [1:0] {
    BR_NONE,
    BR_COND,
    BR_UNCOND
  } br_class_e;

endpackage

// File: rtl/bpu_counter_table.sv
// Array of saturating history counters: combinational read port, one write port,
// synchronous active-low reset to weakly-not-taken.
module bpu_counter_table #(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] ctr [DEPTH];

  // Read sees the pre-update value when a write to the same index lands this cycle.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (wr_en) begin
      if (wr_taken && (ctr[wr_idx] != CTR_MAX)) begin
        ctr[wr_idx] <= ctr[wr_idx] + CTR_W'(1);
      end else if (!wr_taken && (ctr[wr_idx] != '0)) begin
        ctr[wr_idx] <= ctr[wr_idx] - CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: bimodal counter table lookup at fetch, branch resolve/train at execute.
// Optional statistics counters are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [5:0]        operation_code,
  input  logic [5:0]        function_code,
  input  logic              res_pred_taken,
  input  logic              exception_flag,
  output logic              branch_decision,
  output logic              mispredict,
  output logic              res_done,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  import branch_predict_unit_pkg::*;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [CTR_W-1:0] rd_ctr;
  br_class_e        br_class;
  logic             taken_raw;
  logic             dec_next;
  logic             misp_next;
  logic             upd_en;
  logic             unused_bits;

  assign pred_idx    = pred_pc[IDX_W+1:2];
  assign res_idx     = res_pc[IDX_W+1:2];
  assign unused_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

  always_comb begin
    br_class  = BR_NONE;
    taken_raw = 1'b0;
    case (operation_code)
      OP_BEQ:  begin br_class = BR_COND;   taken_raw = (operand_a == operand_b); end
      OP_BNE:  begin br_class = BR_COND;   taken_raw = (operand_a != operand_b); end
      OP_BGEZ: begin br_class = BR_COND;   taken_raw = !operand_a[DATA_W-1];     end
      OP_BLTZ: begin br_class = BR_COND;   taken_raw = operand_a[DATA_W-1];      end
      OP_J,
      OP_JAL:  begin br_class = BR_UNCOND; taken_raw = 1'b1;                     end
      OP_SPECIAL: begin
        case (function_code)
          FUNC_JR,
          FUNC_JALR: begin br_class = BR_UNCOND; taken_raw = 1'b1; end
          FUNC_TEQ:  begin br_class = BR_UNCOND; taken_raw = (operand_a == operand_b); end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  // An exception redirects unconditionally and never trains the table.
  assign dec_next  = exception_flag | taken_raw;
  assign misp_next = exception_flag | (taken_raw ^ res_pred_taken);
  assign upd_en    = res_valid & ~exception_flag & (br_class == BR_COND);

  bpu_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .rd_idx   (pred_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (upd_en),
    .wr_idx   (res_idx),
    .wr_taken (taken_raw)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      pred_valid      <= 1'b0;
      pred_taken      <= 1'b0;
      res_done        <= 1'b0;
      branch_decision <= 1'b0;
      mispredict      <= 1'b0;
    end else begin
      pred_valid      <= pred_req;
      pred_taken      <= pred_req & rd_ctr[CTR_W-1];
      res_done        <= res_valid;
      branch_decision <= res_valid & dec_next;
      mispredict      <= res_valid & misp_next;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] misp_cnt;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      branch_cnt <= '0;
      misp_cnt   <= '0;
    end else begin
      if (upd_en && (branch_cnt != 32'hFFFF_FFFF)) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict && (misp_cnt != 32'hFFFF_FFFF)) misp_cnt <= misp_cnt + 32'd1;
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = misp_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a reference predictor model pushes expected
// results per driven cycle, which are popped and compared one cycle later.
module tb_branch_predict_unit;

  import branch_predict_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [5:0]  operation_code;
  logic [5:0]  function_code;
  logic        res_pred_taken;
  logic        exception_flag;
  logic        branch_decision;
  logic        mispredict;
  logic        res_done;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk_in = ~clk_in;

  branch_predict_unit dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .pred_req         (pred_req),
    .pred_pc          (pred_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .operation_code   (operation_code),
    .function_code    (function_code),
    .res_pred_taken   (res_pred_taken),
    .exception_flag   (exception_flag),
    .branch_decision  (branch_decision),
    .mispredict       (mispredict),
    .res_done         (res_done),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic pv;
    logic pt;
    logic done;
    logic dec;
    logic misp;
  } exp_t;

  exp_t sb_q[$];
  int   mdl[64];
  int   exp_branches;
  int   exp_misps;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    exp_branches = 0;
    exp_misps    = 0;
  endtask

  function automatic void ref_decide(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic dec, output logic cond);
    dec  = 1'b0;
    cond = 1'b0;
    case (op)
      OP_BEQ:  begin cond = 1'b1; dec = (a == b); end
      OP_BNE:  begin cond = 1'b1; dec = (a != b); end
      OP_BGEZ: begin cond = 1'b1; dec = ($signed(a) >= 0); end
      OP_BLTZ: begin cond = 1'b1; dec = ($signed(a) < 0); end
      OP_J, OP_JAL: dec = 1'b1;
      OP_SPECIAL: dec = (fn == FUNC_JR) || (fn == FUNC_JALR) || ((fn == FUNC_TEQ) && (a == b));
      default: ;
    endcase
  endfunction

  task automatic drive_idle();
    pred_req       = 1'b0;
    pred_pc        = '0;
    res_valid      = 1'b0;
    res_pc         = '0;
    operand_a      = '0;
    operand_b      = '0;
    operation_code = '0;
    function_code  = '0;
    res_pred_taken = 1'b0;
    exception_flag = 1'b0;
  endtask

  task automatic step(input string tag, input logic preq, input logic [31:0] ppc,
                      input logic rv, input logic [31:0] rpc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic rpt, input logic exc);
    exp_t e;
    exp_t got;
    logic dec;
    logic cond;
    int   pidx;
    int   ridx;
    pred_req       = preq;
    pred_pc        = ppc;
    res_valid      = rv;
    res_pc         = rpc;
    operand_a      = a;
    operand_b      = b;
    operation_code = op;
    function_code  = fn;
    res_pred_taken = rpt;
    exception_flag = exc;
    pidx = int'(ppc[7:2]);
    ridx = int'(rpc[7:2]);
    ref_decide(op, fn, a, b, dec, cond);
    e.pv   = preq;
    e.pt   = preq && (mdl[pidx] >= 2);
    e.done = rv;
    e.dec  = rv && (exc || dec);
    e.misp = rv && (exc || (dec ^ rpt));
    if (rv && cond && !exc) begin
      if (dec && mdl[ridx] < 3) mdl[ridx]++;
      if (!dec && mdl[ridx] > 0) mdl[ridx]--;
      exp_branches++;
    end
    if (e.misp) exp_misps++;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    got = sb_q.pop_front();
    check_eq({tag, ".pred_valid"}, 32'(pred_valid), 32'(got.pv));
    if (got.pv) check_eq({tag, ".pred_taken"}, 32'(pred_taken), 32'(got.pt));
    check_eq({tag, ".res_done"}, 32'(res_done), 32'(got.done));
    check_eq({tag, ".decision"}, 32'(branch_decision), 32'(got.dec));
    check_eq({tag, ".mispredict"}, 32'(mispredict), 32'(got.misp));
  endtask

  task automatic predict(input string tag, input logic [31:0] pc);
    step(tag, 1'b1, pc, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] op, input logic [5:0] fn,
                         input logic rpt, input logic exc);
    step(tag, 1'b0, '0, 1'b1, pc, a, b, op, fn, rpt, exc);
  endtask

  task automatic check_stats(input string tag);
`ifdef BPU_STATS_EN
    check_eq({tag, ".stat_branches"}, stat_branches, 32'(exp_branches));
    check_eq({tag, ".stat_mispredicts"}, stat_mispredicts, 32'(exp_misps));
`else
    check_eq({tag, ".stat_branches"}, stat_branches, 32'd0);
    check_eq({tag, ".stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    reset_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst.pred_valid", 32'(pred_valid), 32'd0);
    check_eq("rst.res_done", 32'(res_done), 32'd0);
    check_eq("rst.decision", 32'(branch_decision), 32'd0);
    check_eq("rst.mispredict", 32'(mispredict), 32'd0);
    check_stats("rst");
    reset_in = 1'b1;

    predict("init_pred", 32'h100);
    resolve("beq1", 32'h100, 32'd5, 32'd5, OP_BEQ, 6'h0, 1'b0, 1'b0);
    resolve("beq2", 32'h100, 32'd5, 32'd5, OP_BEQ, 6'h0, 1'b0, 1'b0);
    predict("beq_pred", 32'h100);

    resolve("bgez_neg", 32'h40, 32'hFFFF_FFFF, 32'd0, OP_BGEZ, 6'h0, 1'b0, 1'b0);
    resolve("bltz_neg", 32'h40, 32'hFFFF_FFFF, 32'd0, OP_BLTZ, 6'h0, 1'b0, 1'b0);
    resolve("bgez_zero", 32'h40, 32'd0, 32'd0, OP_BGEZ, 6'h0, 1'b1, 1'b0);
    resolve("bne_ne", 32'h40, 32'd1, 32'd2, OP_BNE, 6'h0, 1'b1, 1'b0);
    predict("mix_pred", 32'h40);

    resolve("exc_bne", 32'h80, 32'd9, 32'd9, OP_BNE, 6'h0, 1'b0, 1'b1);
    resolve("exc_beq", 32'h80, 32'd9, 32'd9, OP_BEQ, 6'h0, 1'b1, 1'b1);
    predict("exc_pred", 32'h80);

    step("same_idx", 1'b1, 32'hC, 1'b1, 32'hC, 32'd7, 32'd7, OP_BEQ, 6'h0, 1'b0, 1'b0);
    predict("same_after", 32'hC);

    for (int i = 0; i < 4; i++) resolve("sat_hi", 32'h20, 32'd3, 32'd3, OP_BEQ, 6'h0, 1'b1, 1'b0);
    predict("sat_hi_pred", 32'h20);
    resolve("sat_hi_dn", 32'h20, 32'd3, 32'd4, OP_BEQ, 6'h0, 1'b1, 1'b0);
    predict("sat_hi_pred2", 32'h20);
    for (int i = 0; i < 3; i++) resolve("sat_lo", 32'h24, 32'd1, 32'd1, OP_BNE, 6'h0, 1'b0, 1'b0);
    resolve("sat_lo_up", 32'h24, 32'd1, 32'd2, OP_BNE, 6'h0, 1'b0, 1'b0);
    predict("sat_lo_pred", 32'h24);

    resolve("j", 32'h14, 32'd0, 32'd0, OP_J, 6'h0, 1'b0, 1'b0);
    resolve("jal", 32'h14, 32'd0, 32'd0, OP_JAL, 6'h0, 1'b1, 1'b0);
    resolve("jr", 32'h14, 32'd0, 32'd0, OP_SPECIAL, FUNC_JR, 1'b0, 1'b0);
    resolve("jalr", 32'h14, 32'd0, 32'd0, OP_SPECIAL, FUNC_JALR, 1'b1, 1'b0);
    resolve("teq_eq", 32'h14, 32'd4, 32'd4, OP_SPECIAL, FUNC_TEQ, 1'b0, 1'b0);
    resolve("teq_ne", 32'h14, 32'd4, 32'd5, OP_SPECIAL, FUNC_TEQ, 1'b1, 1'b0);
    predict("jump_pred", 32'h14);
    resolve("other_op", 32'h14, 32'd0, 32'd0, 6'h3F, 6'h0, 1'b1, 1'b0);
    resolve("special_other", 32'h14, 32'd0, 32'd0, OP_SPECIAL, 6'h20, 1'b0, 1'b0);
    step("no_res", 1'b0, '0, 1'b0, 32'h14, 32'd1, 32'd1, OP_BEQ, 6'h0, 1'b1, 1'b1);
    step("both", 1'b1, 32'h100, 1'b1, 32'h40, 32'd8, 32'd8, OP_BNE, 6'h0, 1'b1, 1'b0);

    step("idle1", 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    step("idle2", 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    check_stats("run");

    pred_req       = 1'b1;
    pred_pc        = 32'h100;
    res_valid      = 1'b1;
    res_pc         = 32'h100;
    operand_a      = 32'd1;
    operand_b      = 32'd1;
    operation_code = OP_BEQ;
    res_pred_taken = 1'b0;
    reset_in       = 1'b0;
    @(posedge clk_in);
    #1;
    model_reset();
    check_eq("midrst.pred_valid", 32'(pred_valid), 32'd0);
    check_eq("midrst.res_done", 32'(res_done), 32'd0);
    check_eq("midrst.decision", 32'(branch_decision), 32'd0);
    check_eq("midrst.mispredict", 32'(mispredict), 32'd0);
    check_stats("midrst");
    drive_idle();
    reset_in = 1'b1;
    predict("midrst_pred", 32'h100);

    resolve("st_beq", 32'h30, 32'd2, 32'd2, OP_BEQ, 6'h0, 1'b1, 1'b0);
    resolve("st_bne", 32'h30, 32'd2, 32'd2, OP_BNE, 6'h0, 1'b0, 1'b0);
    resolve("st_bgez", 32'h30, 32'd5, 32'd0, OP_BGEZ, 6'h0, 1'b1, 1'b0);
    resolve("st_bltz", 32'h30, 32'd5, 32'd0, OP_BLTZ, 6'h0, 1'b1, 1'b0);
    step("st_idle1", 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    step("st_idle2", 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef BPU_STATS_EN
    check_eq("stats4.branches", stat_branches, 32'd4);
    check_eq("stats4.mispredicts", stat_mispredicts, 32'd1);
`else
    check_stats("stats4");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
